rptr_empty_ctrl: RTL and testbench
==================================

# rptr_empty_ctrl

Read-side pointer and empty-flag controller for the dual-clock FIFO; the counterpart of the write-pointer/full logic. It lives entirely in the read clock domain. It advances a binary read pointer on accepted reads and drives the memory read address. It publishes a Gray-coded read pointer for synchronisation into the write domain, and derives registered empty, almost-empty, fill-level and underflow-error status from the write pointer after it has been synchronised into the read domain.

## Interface
- ADDR_LINES, 8, memory address width; FIFO depth = 2^ADDR_LINES, pointers are ADDR_LINES+1 bits
- AEMPTY_THRESH, 16, ralmost_empty asserts when fill level <= this value

- rclk  in  1  read-domain clock
- rrst  in  1  reset, synchronous, active-high
- rinc  in  1  read request; honoured only when rempty=0
- rq2_wptr  in  ADDR_LINES+1  Gray write pointer, already double-synchronised into rclk
- raddr  out  ADDR_LINES  binary memory read address = rbin[ADDR_LINES-1:0]
- rptr  out  ADDR_LINES+1  registered Gray read pointer, sent to write-domain synchroniser
- rempty  out  1  registered FIFO-empty flag
- ralmost_empty  out  1  registered almost-empty flag
- rlevel  out  ADDR_LINES+1  registered fill level, 0..2^ADDR_LINES
- rerr_underflow  out  1  sticky: a read was attempted while empty

## Operation
- rd_fire = rinc & ~rempty; rbinnext = rbin + rd_fire, modulo 2^(ADDR_LINES+1); rgraynext = (rbinnext >> 1) ^ rbinnext.
- On each rclk edge: rbin <= rbinnext, rptr <= rgraynext.
- rempty <= (rgraynext == rq2_wptr). The comparison uses the next pointer, so the flag is correct on the same edge that consumes the last word.
- wbin_s = Gray-to-binary(rq2_wptr), a combinational XOR prefix.
- rlevel <= wbin_s - rbinnext, modulo 2^(ADDR_LINES+1).
- ralmost_empty <= (that value <= AEMPTY_THRESH).
- rerr_underflow <= rerr_underflow | (rinc & rempty). It is cleared only by rrst.
- A read while empty does not move rbin or rptr.
- Read data comes from external memory addressed by raddr. The word at raddr is valid whenever rempty=0. A read is consumed on the edge where rd_fire=1.
- Wrap-around: rbin rolls over from 2^(ADDR_LINES+1)-1 to 0, and raddr wraps from 2^ADDR_LINES-1 to 0. The MSB toggle is what separates full from empty in the write domain.
- Reset, including mid-operation: every register takes its reset value regardless of rq2_wptr. rempty is forced to 1 for that cycle. The following cycle recomputes all status from rq2_wptr. The read and write domains must be reset together; the block does not check this.

## Timing
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, rerr_underflow=0.
- A read accepted at edge N updates raddr, rptr, rempty, rlevel and ralmost_empty at edge N, visible in cycle N+1.
- A change on rq2_wptr is reflected in rempty, rlevel and ralmost_empty one rclk edge later.
- End-to-end write-to-not-empty latency is the 2-stage synchroniser plus 1 cycle.
- Simultaneous read and rq2_wptr advance: both are folded into the same edge, so rlevel is unchanged when one word is written and one is read.
- rerr_underflow asserts one edge after the offending rinc.

## Configuration
- RPTR_LEVEL_EN defined: the Gray-to-binary converter, subtractor, rlevel and ralmost_empty logic are built as described.
- RPTR_LEVEL_EN undefined: rlevel is tied to 0, and ralmost_empty is a copy of the rempty register. Pointer, empty and underflow behaviour is unchanged.

## Test plan
- Reset: rrst=1 for one edge with rq2_wptr=0x005 -> rptr=0, raddr=0, rempty=1, rlevel=0, rerr_underflow=0. After release with rinc=0 -> rempty=0, rlevel=6.
- Drain: rq2_wptr=0x002 (Gray 3), then rinc=1 for 3 cycles -> raddr 1,2,3; rempty=1 on the third edge; rptr=0x002; rlevel 2,1,0.
- Underflow: rempty=1, rinc=1 for one cycle -> rptr and raddr unchanged, rerr_underflow=1 next cycle and held until rrst.
- Full level: rbin=0, rq2_wptr=0x180 (Gray 256) -> rlevel=256, rempty=0, ralmost_empty=0.
- Threshold: rlevel=17, one read -> rlevel=16 and ralmost_empty=1 on that same edge. With RPTR_LEVEL_EN undefined -> ralmost_empty tracks rempty.
- Wrap: read continuously for 512 accepted reads while rq2_wptr is advanced ahead -> rptr goes 0x100 -> 0x000, raddr goes 255 -> 0, no spurious rempty.

Source files
------------

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty flag and fill-level status for a dual-clock FIFO (read clock domain).
// Define RPTR_LEVEL_EN to build the fill-level / almost-empty logic; otherwise rlevel=0 and ralmost_empty mirrors rempty.
module rptr_empty_ctrl #(
    parameter int ADDR_LINES    = 8,
    parameter int AEMPTY_THRESH = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [ADDR_LINES:0]   rq2_wptr,
    output logic [ADDR_LINES-1:0] raddr,
    output logic [ADDR_LINES:0]   rptr,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_LINES:0]   rlevel,
    output logic                  rerr_underflow
);
    localparam int PW = ADDR_LINES + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic          rd_fire;

    assign rd_fire   = rinc & ~rempty;
    assign rbinnext  = rbin + PW'(rd_fire);
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign raddr     = rbin[ADDR_LINES-1:0];

    // Empty is judged on the next pointer so the flag rises on the edge that takes the last word.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin           <= '0;
            rptr           <= '0;
            rempty         <= 1'b1;
            rerr_underflow <= 1'b0;
        end else begin
            rbin           <= rbinnext;
            rptr           <= rgraynext;
            rempty         <= (rgraynext == rq2_wptr);
            rerr_underflow <= rerr_underflow | (rinc & rempty);
        end
    end

`ifdef RPTR_LEVEL_EN
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] level_next;

    // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < PW; i++)
            wbin_s[i] = ^(rq2_wptr >> i);
    end

    assign level_next = wbin_s - rbinnext;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rlevel        <= level_next;
            ralmost_empty <= (level_next <= THRESH);
        end
    end
`else
    assign rlevel        = '0;
    assign ralmost_empty = rempty;
`endif

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Randomized bench for rptr_empty_ctrl against a count-based model of reads and writes.
module tb_rptr_empty_ctrl;
    localparam int AL  = 8;
    localparam int PW  = AL + 1;
    localparam int MOD = 1 << PW;
    localparam int TH  = 16;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          rinc;
    logic [PW-1:0] rq2_wptr;
    logic [AL-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          rempty;
    logic          ralmost_empty;
    logic [PW-1:0] rlevel;
    logic          rerr_underflow;

    rptr_empty_ctrl #(.ADDR_LINES(AL), .AEMPTY_THRESH(TH)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .rlevel(rlevel),
        .rerr_underflow(rerr_underflow)
    );

    always #5 rclk = ~rclk;

    int n_chk = 0;
    int n_err = 0;

    // Model: number of words read and written (mod 2^(AL+1)), plus flags.
    int m_rd    = 0;
    int m_w     = 0;
    bit m_empty = 1'b1;
    bit m_err   = 1'b0;
    int m_lvl   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    // Apply one cycle of stimulus, advance the model, then check all outputs.
    task automatic cycle(input bit rst, input bit inc, input int w);
        bit fire;
        m_w      = w % MOD;
        rrst     = rst;
        rinc     = inc;
        rq2_wptr = PW'(gray(m_w));
        @(posedge rclk);
        if (rst) begin
            m_rd = 0; m_empty = 1'b1; m_err = 1'b0; m_lvl = 0;
        end else begin
            fire    = inc && !m_empty;
            m_err   = m_err | (inc && m_empty);
            m_rd    = (m_rd + int'(fire)) % MOD;
            m_lvl   = (m_w - m_rd + MOD) % MOD;
            m_empty = (m_lvl == 0);
        end
        #1;
        chk("rptr",   int'(rptr),   gray(m_rd));
        chk("raddr",  int'(raddr),  m_rd % (1 << AL));
        chk("rempty", int'(rempty), int'(m_empty));
        chk("rerr",   int'(rerr_underflow), int'(m_err));
`ifdef RPTR_LEVEL_EN
        chk("rlevel", int'(rlevel), rst ? 0 : m_lvl);
        chk("raempty", int'(ralmost_empty), rst ? 1 : int'(m_lvl <= TH));
`else
        chk("rlevel", int'(rlevel), 0);
        chk("raempty", int'(ralmost_empty), int'(m_empty));
`endif
    endtask

    initial begin
        int w;
        rrst = 1'b1; rinc = 1'b0; rq2_wptr = '0;

        // Reset with a non-zero write pointer, then release.
        cycle(1, 0, 5);
        cycle(0, 0, 5);
        cycle(0, 0, 5);

        // Drain three words to empty.
        cycle(1, 0, 3);
        for (int i = 0; i < 3; i++) cycle(0, 1, 3);

        // Underflow: sticky until reset.
        cycle(0, 1, 3);
        for (int i = 0; i < 4; i++) cycle(0, 0, 3);
        cycle(1, 0, 3);
        cycle(0, 0, 3);

        // Full level.
        cycle(1, 0, 0);
        cycle(0, 0, 256);
        cycle(0, 0, 256);

        // Threshold crossing: 17 -> 16 on one read.
        cycle(1, 0, 0);
        cycle(0, 0, 17);
        cycle(0, 1, 17);
        cycle(0, 0, 17);

        // Wrap: continuous reads with the writer kept ahead.
        cycle(1, 0, 0);
        cycle(0, 0, 4);
        for (int i = 0; i < 560; i++) cycle(0, 1, m_rd + 4);

        // Random traffic with occasional mid-operation reset.
        w = m_w;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                w = $urandom_range(0, 20);
                cycle(1, 1'($urandom_range(0, 1)), w);
            end else begin
                if ($urandom_range(0, 99) < 45 && ((w - m_rd + MOD) % MOD) < 256)
                    w = (w + 1) % MOD;
                cycle(0, $urandom_range(0, 99) < 50, w);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
